// File: rtl/gray_updown_counter.sv
// Loadable up/down counter holding its count in binary and Gray code at once.
// The Gray output is registered directly so it can cross clock domains safely;
// the binary output is used locally. Gray-coded loads are converted with a
// WIDTH-generic prefix XOR before being stored as the binary state.
module gray_updown_counter #(
    parameter int          WIDTH    = 4,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // Prefix XOR from the MSB down: b[i] = b[i+1] ^ g[i].
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_q;
    logic             wrap_d;

    // Next state: load beats count beats hold; wrap flags only a count that rolls over.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_is_gray ? gray2bin(load_val) : load_val;
        end else if (en) begin
            if (up) begin
                if (bin_q == MAX_VAL) begin
                    if (SATURATE) begin
                        bin_d = bin_q;
                    end else begin
                        bin_d  = MIN_VAL;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q + ONE;
                end
            end else begin
                if (bin_q == MIN_VAL) begin
                    if (SATURATE) begin
                        bin_d = bin_q;
                    end else begin
                        bin_d  = MAX_VAL;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q - ONE;
                end
            end
        end
        // Gray is derived from the next binary value so both registers always agree.
        gray_d = bin2gray(bin_d);
    end

    // State registers; reset forces RST_VAL into both encodings immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;
    assign at_max   = (bin_q == MAX_VAL);
    assign at_min   = (bin_q == MIN_VAL);

endmodule

// File: doc/gray_updown_counter.md
Name: gray_updown_counter

Overview:
- Parametrised, loadable up/down counter that keeps its count in Gray code and in binary at the same time.
- Next-generation successor to the fixed 4-bit combinational Gray-to-binary converter.
- Holds state, so it can serve as a CDC-safe pointer or position source. The Gray output crosses clock domains; the binary output is used locally.
- Gray-coded loads go through an internal WIDTH-generic Gray-to-binary conversion (prefix XOR).

Parameters:
- WIDTH, 4: counter width in bits; legal range 2..32.
- SATURATE, 0: 0 = count wraps modulo 2^WIDTH; 1 = count holds at the limit.
- RST_VAL, 0: binary value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_is_gray  input  1  1 = load_val is Gray-coded; 0 = load_val is binary.
- load_val  input  WIDTH  value to load.
- gray_out  output  WIDTH  registered count, Gray code.
- bin_out  output  WIDTH  registered count, binary.
- wrap  output  1  one-cycle pulse on modulo wrap-around.
- at_max  output  1  high when bin_out == 2^WIDTH-1.
- at_min  output  1  high when bin_out == 0.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high.
  - On rst, outputs take these values immediately, without waiting for clk:
    - bin_out = RST_VAL
    - gray_out = RST_VAL ^ (RST_VAL >> 1)
    - wrap = 0
    - at_max and at_min follow RST_VAL.
  - Reset asserted mid-count aborts the step in progress. The first step after release occurs on the first rising edge with rst low.
- State and output invariant:
  - State is bin_q. gray_q is registered in the same cycle as bin_q.
  - gray_out == bin_out ^ (bin_out >> 1) after every edge. A mismatch is a design error.
- Next-state priority per rising edge: load > en > hold.
- Load (load = 1):
  - load_is_gray = 0: bin_q <= load_val.
  - load_is_gray = 1: bin_q[WIDTH-1] <= g[WIDTH-1]; bin_q[i] <= bin_q_next[i+1] ^ g[i], from MSB down (prefix XOR over the full width).
  - Load ignores en and up and never raises wrap.
- Count (load = 0, en = 1):
  - up = 1: bin + 1.
  - up = 0: bin - 1.
- Wrap-around when SATURATE = 0:
  - Up from 2^WIDTH-1 gives 0. Down from 0 gives 2^WIDTH-1.
  - wrap = 1 for exactly the cycle after the wrapping edge, otherwise 0.
- Saturation when SATURATE = 1:
  - Up at max holds; down at min holds.
  - gray_out does not change and wrap is never asserted.
- Hold (en = 0, load = 0): outputs unchanged; wrap = 0.
- Latency: one cycle from an input edge to the updated outputs. at_max and at_min are decoded from the registered bin_q.
- Gray property: every en-driven step that changes the count changes exactly one bit of gray_out, including the wrap step. Loads may change any number of bits.
- Direction change on consecutive cycles is legal. Each step uses the up value sampled at that edge.

Test Plan:
- Reset and wrap-up: WIDTH = 4, RST_VAL = 0. Hold rst, release, en = 1, up = 1 for 16 cycles.
  - Required: gray_out runs 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000.
  - Required: wrap pulses exactly once, on the 0000 return.
- Down wrap: from 0, en = 1, up = 0 for one cycle.
  - Required: bin_out = 1111, gray_out = 1000, wrap = 1 for one cycle, at_max = 1.
- Gray load: load = 1, load_is_gray = 1, load_val = 1010.
  - Required: bin_out = 1100, gray_out = 1010, wrap = 0.
- Priority: load_is_gray = 0, load_val = 0101, with load = 1 and en = 1 together.
  - Required: bin_out = 0101 (load wins); the next cycle counts from 0101.
- Saturation: SATURATE = 1, load 1111, en = 1, up = 1 for 3 cycles.
  - Required: bin_out stays 1111, gray_out stays 1000, wrap never asserts.
- Async reset mid-count: assert rst between clock edges while counting at 0111.
  - Required: outputs go to RST_VAL before the next edge; every step asserts the one-bit-change check on gray_out.
